// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and helpers for the matrix-keypad scanner:
//               debounce FSM state encoding, key-event record, code-width
//               and key-code helpers.
//               No ports (package).
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  // Widest key code supported (8 rows x 8 columns = 64 keys).
  localparam int MAX_CW = 6;

  // Default geometry of the block and the resulting event layout.
  localparam int KP_ROWS_DEF = 4;
  localparam int KP_COLS_DEF = 4;
  localparam int KP_CW_DEF   = $clog2(KP_ROWS_DEF * KP_COLS_DEF);
  localparam int KP_EW_DEF   = KP_CW_DEF + 1;

  // Debounce FSM states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSING  = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } kp_state_t;

  // Key event record: release flag plus key code (widest layout).
  typedef struct packed {
    logic              rel;
    logic [MAX_CW-1:0] code;
  } kp_evt_t;

  // Code width for a given matrix geometry.
  function automatic int kp_cw(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

  // Row-major key code: row * COLS + col.
  function automatic logic [MAX_CW-1:0] kp_key_code(input int row, input int col,
                                                    input int cols);
    return MAX_CW'(row * cols + col);
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : keypad_evt_fifo
// Description : Synchronous event FIFO with occupancy and full/empty flags.
//               Head entry is presented combinationally from storage and is
//               forced to zero while empty.
// Ports       : clk, reset       - clock, synchronous active-high reset
//               push, push_data  - write request / data (ignored when full
//                                  unless a pop happens in the same cycle)
//               pop              - advance head (ignored when empty)
//               pop_data         - head entry
//               level            - occupancy 0..DEPTH
//               full, empty      - status flags
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_evt_fifo #(
  parameter int DEPTH = 8,   // power of two, >= 2
  parameter int WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == (AW+1)'(DEPTH));

  // A pop frees a slot in the same cycle, so push+pop on a full FIFO succeeds.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
  assign level    = level_q;

endmodule
`default_nettype wire

// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_matrix_scanner
// Description : Parametrised matrix-keypad scanner. Drives one column low at
//               a time, samples the synchronised rows, reduces each sweep to
//               the lowest pressed code, debounces over whole sweeps and
//               queues press/release events in a FIFO popped via valid/ready.
// Ports       : clk, reset   - clock, synchronous active-high reset
//               enable       - scan enable
//               row_n        - row inputs, active-low, asynchronous
//               col_n        - column drive, active-low, one-cold
//               evt_valid    - FIFO head valid
//               evt_ready    - pop head when evt_valid & evt_ready
//               evt_data     - {release, code}, code = row*COLS+col
//               evt_level    - FIFO occupancy
//               overflow     - sticky, event dropped on full FIFO
//               ovf_clr      - clears overflow
//               irq          - evt_valid | overflow
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4,
  parameter int DEPTH    = 8,
  parameter int REL_EVT  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [ROWS-1:0]             row_n,
  output logic [COLS-1:0]             col_n,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [$clog2(ROWS*COLS):0]  evt_data,
  output logic [$clog2(DEPTH):0]      evt_level,
  output logic                        overflow,
  input  logic                        ovf_clr,
  output logic                        irq
);

  localparam int CW      = kp_cw(ROWS, COLS);
  localparam int EW      = CW + 1;
  localparam int DW      = $clog2(SCAN_DIV);
  localparam int COLW    = $clog2(COLS);
  localparam int ROWW    = $clog2(ROWS);
  localparam bit DEB_ONE = (DEBOUNCE <= 1);

  // --------------------------------------------------------------------------
  // Row synchroniser
  // --------------------------------------------------------------------------
  logic [ROWS-1:0] row_s1_q, row_s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      row_s1_q <= '1;
      row_s2_q <= '1;
    end else begin
      row_s1_q <= row_n;
      row_s2_q <= row_s1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Column scanner and sweep encoder
  // --------------------------------------------------------------------------
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [COLW-1:0] col_q, col_d;
  logic [COLS-1:0] col_n_q, col_n_d;
  logic            acc_any_q, acc_any_d;
  logic [CW-1:0]   acc_code_q, acc_code_d;

  logic            sample_now, sweep_end;
  logic            col_hit;
  logic [ROWW-1:0] col_row;
  logic [CW-1:0]   col_code;
  logic            fin_any;
  logic [CW-1:0]   fin_code;

  // Lowest pressed row in the column being sampled. Rows are sampled at the
  // end of the dwell, so the synchroniser delay stays inside the dwell window.
  always_comb begin
    sample_now = enable && (dwell_q == DW'(SCAN_DIV - 1));
    sweep_end  = sample_now && (col_q == COLW'(COLS - 1));
    col_hit    = 1'b0;
    col_row    = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!row_s2_q[r]) begin
        col_hit = 1'b1;
        col_row = ROWW'(r);
      end
    end
    col_code = CW'(kp_key_code(int'(col_row), int'(col_q), COLS));
  end

  // Columns are visited in order but codes are row-major, so a later column
  // can still carry a lower code: keep a running minimum across the sweep.
  always_comb begin
    fin_any  = acc_any_q | col_hit;
    fin_code = acc_code_q;
    if (col_hit && (!acc_any_q || (col_code < acc_code_q))) fin_code = col_code;
  end

  always_comb begin
    dwell_d    = dwell_q;
    col_d      = col_q;
    acc_any_d  = acc_any_q;
    acc_code_d = acc_code_q;
    if (!enable) begin
      dwell_d    = '0;
      col_d      = '0;
      acc_any_d  = 1'b0;
      acc_code_d = '0;
    end else if (sample_now) begin
      dwell_d = '0;
      if (col_q == COLW'(COLS - 1)) begin
        col_d      = '0;
        acc_any_d  = 1'b0;
        acc_code_d = '0;
      end else begin
        col_d      = col_q + COLW'(1);
        acc_any_d  = fin_any;
        acc_code_d = fin_code;
      end
    end else begin
      dwell_d = dwell_q + DW'(1);
    end
    // Drive follows the column register so the pins change with the index.
    col_n_d = enable ? ~(COLS'(1) << col_d) : '1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_q    <= '0;
      col_q      <= '0;
      col_n_q    <= '1;
      acc_any_q  <= 1'b0;
      acc_code_q <= '0;
    end else begin
      dwell_q    <= dwell_d;
      col_q      <= col_d;
      col_n_q    <= col_n_d;
      acc_any_q  <= acc_any_d;
      acc_code_q <= acc_code_d;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce FSM: acts once per sweep on the final sweep result and registers
  // the push, which therefore lands in the cycle after the last sample.
  // --------------------------------------------------------------------------
  kp_state_t     state_q;
  logic [3:0]    cnt_q;
  logic [CW-1:0] key_q;
  logic          push_q;
  kp_evt_t       push_evt_q;
  logic [4:0]    cnt_next;
  logic          cnt_reach;

  assign cnt_next  = {1'b0, cnt_q} + 5'd1;
  assign cnt_reach = (cnt_next >= 5'(DEBOUNCE));

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      key_q      <= '0;
      push_q     <= 1'b0;
      push_evt_q <= '0;
    end else begin
      push_q <= 1'b0;
      if (sweep_end) begin
        case (state_q)
          IDLE: begin
            if (fin_any) begin
              key_q <= fin_code;
              if (DEB_ONE) begin
                state_q    <= HELD;
                push_q     <= 1'b1;
                push_evt_q <= '{rel: 1'b0, code: MAX_CW'(fin_code)};
              end else begin
                state_q <= PRESSING;
                cnt_q   <= 4'd1;
              end
            end
          end
          PRESSING: begin
            if (!fin_any) begin
              state_q <= IDLE;
            end else if (fin_code != key_q) begin
              key_q <= fin_code;
              cnt_q <= 4'd1;
            end else if (cnt_reach) begin
              state_q    <= HELD;
              push_q     <= 1'b1;
              push_evt_q <= '{rel: 1'b0, code: MAX_CW'(key_q)};
            end else begin
              cnt_q <= cnt_next[3:0];
            end
          end
          HELD: begin
            if (!fin_any || (fin_code != key_q)) begin
              if (DEB_ONE) begin
                state_q    <= IDLE;
                push_q     <= (REL_EVT != 0);
                push_evt_q <= '{rel: 1'b1, code: MAX_CW'(key_q)};
              end else begin
                state_q <= RELEASING;
                cnt_q   <= 4'd1;
              end
            end
          end
          RELEASING: begin
            if (fin_any && (fin_code == key_q)) begin
              state_q <= HELD;
            end else if (cnt_reach) begin
              state_q    <= IDLE;
              push_q     <= (REL_EVT != 0);
              push_evt_q <= '{rel: 1'b1, code: MAX_CW'(key_q)};
            end else begin
              cnt_q <= cnt_next[3:0];
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Event record is stored at its widest; only CW code bits reach the FIFO.
  if (CW < MAX_CW) begin : g_code_pad
    logic unused_code_hi;
    assign unused_code_hi = ^push_evt_q.code[MAX_CW-1:CW];
  end

  // --------------------------------------------------------------------------
  // Event FIFO and overflow
  // --------------------------------------------------------------------------
  logic [EW-1:0] fifo_wdata;
  logic          fifo_full, fifo_empty, fifo_pop, evt_drop;
  logic          overflow_q, overflow_d;

  assign fifo_wdata = {push_evt_q.rel, push_evt_q.code[CW-1:0]};
  assign fifo_pop   = evt_ready & ~fifo_empty;
  assign evt_drop   = push_q & fifo_full & ~fifo_pop;

  // A drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    overflow_d = evt_drop | (overflow_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  keypad_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_evt_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_q),
    .push_data (fifo_wdata),
    .pop       (evt_ready),
    .pop_data  (evt_data),
    .level     (evt_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign col_n     = col_n_q;
  assign evt_valid = ~fifo_empty;
  assign overflow  = overflow_q;
  assign irq       = ~fifo_empty | overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_keypad_matrix_scanner
// Description : Self-checking bench for keypad_matrix_scanner. A key-matrix
//               model turns pressed keys and driven columns into row_n;
//               expected events are queued when keys change and compared as
//               they are popped from the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_matrix_scanner;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 4;
  localparam int DEPTH    = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [ROWS-1:0] row_n;
  logic [COLS-1:0] col_n;
  logic            evt_valid;
  logic            evt_ready;
  logic [4:0]      evt_data;
  logic [3:0]      evt_level;
  logic            overflow;
  logic            ovf_clr;
  logic            irq;

  logic [15:0]     keys;
  logic [4:0]      exp_q [$];
  int              n_checks = 0;
  int              n_errors = 0;

  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  keypad_matrix_scanner #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE),
    .DEPTH    (DEPTH),
    .REL_EVT  (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .row_n     (row_n),
    .col_n     (col_n),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .evt_level (evt_level),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .irq       (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns at the falling edge just after col_n wraps 0111 -> 1110; that is
  // the cycle in which a sweep-final push is presented to the FIFO.
  task automatic wait_sweep(input string tag);
    logic [COLS-1:0] prev;
    bit              seen;
    seen = 1'b0;
    prev = col_n;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (prev == 4'b0111 && col_n == 4'b1110) seen = 1'b1;
      prev = col_n;
    end
    check_eq({tag, "_sweep"}, 32'(seen), 32'd1);
  endtask

  task automatic sweeps(input int n, input string tag);
    for (int i = 0; i < n; i++) wait_sweep(tag);
  endtask

  // Pop everything the DUT holds, comparing against the scoreboard.
  task automatic drain(input string tag);
    int popped;
    int expected_n;
    popped     = 0;
    expected_n = exp_q.size();
    @(negedge clk);
    while (evt_valid && popped < 2*DEPTH) begin
      if (exp_q.size() > 0) check_eq({tag, "_data"}, 32'(evt_data), 32'(exp_q.pop_front()));
      popped++;
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
    end
    check_eq({tag, "_count"}, 32'(popped), 32'(expected_n));
    check_eq({tag, "_level"}, 32'(evt_level), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    keys      = '0;
    repeat (3) @(negedge clk);

    // ---- reset values ----
    check_eq("rst_col_n", 32'(col_n), 32'hF);
    check_eq("rst_valid", 32'(evt_valid), 32'd0);
    check_eq("rst_data", 32'(evt_data), 32'd0);
    check_eq("rst_level", 32'(evt_level), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);

    // ---- column sequence, 4 clocks per column ----
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("col0", 32'(col_n), 32'hE);
    repeat (4) @(negedge clk);
    check_eq("col1", 32'(col_n), 32'hD);
    repeat (4) @(negedge clk);
    check_eq("col2", 32'(col_n), 32'hB);
    repeat (4) @(negedge clk);
    check_eq("col3", 32'(col_n), 32'h7);
    repeat (4) @(negedge clk);
    check_eq("col_wrap", 32'(col_n), 32'hE);
    check_eq("idle_valid", 32'(evt_valid), 32'd0);

    // ---- press/release key 9 (row 2, col 1) ----
    wait_sweep("k9");
    keys[9] = 1'b1;
    exp_q.push_back({1'b0, 4'd9});
    sweeps(4, "k9p");
    repeat (2) @(negedge clk);
    check_eq("k9_level1", 32'(evt_level), 32'd1);
    check_eq("k9_head", 32'(evt_data), 32'(exp_q[0]));
    keys[9] = 1'b0;
    exp_q.push_back({1'b1, 4'd9});
    sweeps(4, "k9r");
    repeat (2) @(negedge clk);
    check_eq("k9_level2", 32'(evt_level), 32'd2);
    drain("k9");

    // ---- bounce: 2 sweeps only, no event ----
    wait_sweep("bnc");
    keys[9] = 1'b1;
    sweeps(2, "bncp");
    keys[9] = 1'b0;
    sweeps(6, "bncr");
    check_eq("bounce_level", 32'(evt_level), 32'd0);

    // ---- candidate change 5 -> 6 restarts the count ----
    wait_sweep("chg");
    keys[5] = 1'b1;
    sweeps(2, "chg5");
    keys[5] = 1'b0;
    keys[6] = 1'b1;
    exp_q.push_back({1'b0, 4'd6});
    sweeps(5, "chg6");
    check_eq("chg_level", 32'(evt_level), 32'd1);
    keys[6] = 1'b0;
    exp_q.push_back({1'b1, 4'd6});
    sweeps(5, "chgr");
    drain("chg");

    // ---- two keys together: lowest code wins ----
    wait_sweep("dual");
    keys[3]  = 1'b1;
    keys[12] = 1'b1;
    exp_q.push_back({1'b0, 4'd3});
    sweeps(5, "dualp");
    keys[3]  = 1'b0;
    keys[12] = 1'b0;
    exp_q.push_back({1'b1, 4'd3});
    sweeps(5, "dualr");
    drain("dual");

    // ---- fill FIFO, then overflow ----
    for (int i = 0; i < DEPTH/2; i++) begin
      keys[9] = 1'b1;
      exp_q.push_back({1'b0, 4'd9});
      sweeps(5, "fillp");
      keys[9] = 1'b0;
      exp_q.push_back({1'b1, 4'd9});
      sweeps(5, "fillr");
    end
    check_eq("full_level", 32'(evt_level), 32'd8);
    check_eq("full_ovf", 32'(overflow), 32'd0);
    keys[9] = 1'b1;
    sweeps(5, "ovfp");
    check_eq("ovf_set", 32'(overflow), 32'd1);
    check_eq("ovf_irq", 32'(irq), 32'd1);
    check_eq("ovf_level", 32'(evt_level), 32'd8);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check_eq("ovf_clr", 32'(overflow), 32'd0);

    // Release aligned to a sweep so the pop lands in the push cycle.
    wait_sweep("pp");
    keys[9] = 1'b0;
    exp_q.push_back({1'b1, 4'd9});
    sweeps(4, "ppr");
    check_eq("pp_head", 32'(evt_data), 32'(exp_q.pop_front()));
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    @(negedge clk);
    check_eq("pp_level", 32'(evt_level), 32'd8);
    check_eq("pp_ovf", 32'(overflow), 32'd0);
    drain("full");

    // ---- reset discards pending entries ----
    for (int i = 0; i < 2; i++) begin
      keys[10] = 1'b1;
      sweeps(5, "r5p");
      keys[10] = 1'b0;
      sweeps(5, "r5r");
    end
    keys[10] = 1'b1;
    sweeps(5, "r5h");
    repeat (3) @(negedge clk);
    check_eq("pre_rst_level", 32'(evt_level), 32'd5);
    reset    = 1'b1;
    keys[10] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_level", 32'(evt_level), 32'd0);
    check_eq("mid_rst_col_n", 32'(col_n), 32'hF);
    check_eq("mid_rst_valid", 32'(evt_valid), 32'd0);
    exp_q.delete();

    // ---- enable low: columns idle, FIFO still poppable ----
    wait_sweep("en");
    keys[10] = 1'b1;
    exp_q.push_back({1'b0, 4'd10});
    sweeps(5, "enp");
    check_eq("en_level", 32'(evt_level), 32'd1);
    enable = 1'b0;
    @(negedge clk);
    check_eq("dis_col_n", 32'(col_n), 32'hF);
    keys[10] = 1'b0;
    drain("dis");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute guard against a hung run.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
